// File: rtl/pcm_sample_fifo.sv
// PCM sample FIFO between the CIC3 decimator and the register file.
// First-word fall-through, watermark irq and sticky overflow.
module pcm_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] pcm_in,
  input  logic             pcm_valid_in,
  input  logic             pop,
  input  logic             flush,
  input  logic             clear_overflow,
  input  logic [LW-1:0]    watermark,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW-1:0]    wr_ptr_nx, rd_ptr_nx;
  logic [LW-1:0]    level_q, level_nx;
  logic             overflow_q, overflow_nx;
  logic             irq_q, irq_nx;
  logic             valid_q;
  logic             is_empty, is_full;
  logic             push_req, do_push, do_pop, ovf_evt;

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == FULL_LVL);

  // One push per filter sample: rising edge of the valid level only.
  assign push_req = pcm_valid_in & ~valid_q & enable;

  // A pop on a full FIFO frees the slot the same-cycle push needs.
  assign do_pop  = pop & ~is_empty & ~flush;
  assign do_push = push_req & ~flush & (~is_full | do_pop);
  assign ovf_evt = push_req & ~flush & is_full & ~do_pop;

  always_comb begin
    wr_ptr_nx   = wr_ptr;
    rd_ptr_nx   = rd_ptr;
    level_nx    = level_q;
    overflow_nx = overflow_q;
    if (flush) begin
      wr_ptr_nx   = '0;
      rd_ptr_nx   = '0;
      level_nx    = '0;
      overflow_nx = 1'b0;
    end else begin
      if (do_push) wr_ptr_nx = wr_ptr + 1'b1;
      if (do_pop)  rd_ptr_nx = rd_ptr + 1'b1;
      level_nx = level_q + LW'(do_push) - LW'(do_pop);
      if (ovf_evt)             overflow_nx = 1'b1;
      else if (clear_overflow) overflow_nx = 1'b0;
    end
    irq_nx = ((watermark != '0) & (level_nx >= watermark))
           | overflow_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nx;
      rd_ptr     <= rd_ptr_nx;
      level_q    <= level_nx;
      overflow_q <= overflow_nx;
      irq_q      <= irq_nx;
      valid_q    <= pcm_valid_in;
    end
  end

  // Storage needs no reset: entries are masked while empty.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= pcm_in;
  end

  assign rd_data  = is_empty ? '0 : mem[rd_ptr];
  assign level    = level_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign overflow = overflow_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Bench for pcm_sample_fifo: queue-based model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_pcm_sample_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] pcm_in = '0;
  logic             pcm_valid_in = 1'b0;
  logic             pop = 1'b0;
  logic             flush = 1'b0;
  logic             clear_overflow = 1'b0;
  logic [LW-1:0]    watermark = '0;
  logic [WIDTH-1:0] rd_data;
  logic [LW-1:0]    level;
  logic             empty, full, overflow, irq;

  pcm_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pcm_in(pcm_in), .pcm_valid_in(pcm_valid_in),
    .pop(pop), .flush(flush), .clear_overflow(clear_overflow),
    .watermark(watermark), .rd_data(rd_data), .level(level),
    .empty(empty), .full(full), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] mq[$];
  bit m_ovf, m_irq, m_vq, m_live;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise, took, ev;
    int sz;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_irq = 0; m_vq = 0; m_live = 1;
    end else begin
      rise = pcm_valid_in && !m_vq && enable;
      m_vq = pcm_valid_in;
      if (flush) begin
        mq.delete();
        m_ovf = 0;
      end else begin
        sz = mq.size();
        took = pop && sz > 0;
        ev = 0;
        if (took) void'(mq.pop_front());
        if (rise) begin
          if (sz < DEPTH || took) mq.push_back(pcm_in);
          else ev = 1;
        end
        if (ev) m_ovf = 1;
        else if (clear_overflow) m_ovf = 0;
      end
      m_irq = (watermark != 0 && mq.size() >= int'(watermark)) || m_ovf;
    end
  endtask

  task automatic model_cmp();
    if (!m_live) return;
    chk("level", 32'(level), 32'(mq.size()));
    chk("rd_data", 32'(rd_data), mq.size() > 0 ? 32'(mq[0]) : 32'd0);
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  // One clock: update the model at the edge, compare after it settles,
  // return at the falling edge where new inputs are driven.
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
    model_cmp();
    @(negedge clk);
  endtask

  task automatic push_s(logic [WIDTH-1:0] d);
    pcm_in = d; pcm_valid_in = 1'b1;
    tick(); tick();
    pcm_valid_in = 1'b0;
    tick();
  endtask

  task automatic pop1();
    pop = 1'b1; tick(); pop = 1'b0;
  endtask

  task automatic flush1();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  initial begin
    int hold, rst_cnt;
    logic [WIDTH-1:0] exp_head;

    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    enable = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_rd", 32'(rd_data), 0);
    chk("rst_irq", 32'(irq), 0);

    // Long valid gives one push only.
    pcm_in = 16'h1234; pcm_valid_in = 1'b1;
    tick();
    chk("first_level", 32'(level), 1);
    chk("first_rd", 32'(rd_data), 32'h1234);
    chk("first_empty", 32'(empty), 0);
    tick(); tick(); tick();
    chk("hold_level", 32'(level), 1);
    pcm_valid_in = 1'b0;
    tick();
    flush1();

    // Fill, overflow, drain in order, clear overflow.
    for (int i = 1; i <= 9; i++) push_s(16'(i));
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_irq", 32'(irq), 1);
    chk("ovf_level", 32'(level), 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_rd", 32'(rd_data), 32'(i));
      pop1();
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_rd0", 32'(rd_data), 0);
    chk("drain_ovf", 32'(overflow), 1);
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_irq", 32'(irq), 0);

    // Watermark at 3.
    watermark = LW'(3);
    push_s(16'h0011); push_s(16'h0022);
    chk("wm_below", 32'(irq), 0);
    pcm_in = 16'h0033; pcm_valid_in = 1'b1;
    tick();
    chk("wm_level", 32'(level), 3);
    chk("wm_irq", 32'(irq), 1);
    pcm_valid_in = 1'b0; tick();
    pop1();
    chk("wm_pop_level", 32'(level), 2);
    chk("wm_pop_irq", 32'(irq), 0);
    flush1();
    watermark = '0;

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) push_s(16'hA000 + 16'(i));
    chk("pp_full", 32'(full), 1);
    pcm_in = 16'hBEEF; pcm_valid_in = 1'b1; pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pp_level", 32'(level), 8);
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_rd", 32'(rd_data), 32'hA001);
    tick(); pcm_valid_in = 1'b0; tick();
    for (int i = 1; i < 8; i++) begin
      chk("pp_order", 32'(rd_data), 32'hA000 + 32'(i));
      pop1();
    end
    chk("pp_last", 32'(rd_data), 32'hBEEF);
    pop1();
    chk("pp_empty", 32'(empty), 1);

    // Flush beats a concurrent push.
    for (int i = 0; i < 5; i++) push_s(16'h0500 + 16'(i));
    chk("fl_pre", 32'(level), 5);
    pcm_in = 16'h5555; pcm_valid_in = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_level", 32'(level), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_ovf", 32'(overflow), 0);
    chk("fl_irq", 32'(irq), 0);
    tick();
    chk("fl_nopush", 32'(level), 0);
    pcm_valid_in = 1'b0; tick();

    // Disabled, empty pop, enable during high valid.
    enable = 1'b0;
    push_s(16'h0BAD); push_s(16'h0BAD);
    chk("dis_level", 32'(level), 0);
    pop1();
    chk("uf_level", 32'(level), 0);
    chk("uf_empty", 32'(empty), 1);
    pcm_in = 16'h0C0C; pcm_valid_in = 1'b1;
    tick(); tick();
    enable = 1'b1;
    tick(); tick();
    chk("en_late", 32'(level), 0);
    pcm_valid_in = 1'b0; tick();

    // Pointer wrap with interleaved pops.
    exp_head = 16'h0100;
    for (int i = 0; i < 20; i++) begin
      push_s(16'h0100 + 16'(i));
      if (i >= 3) begin
        chk("wrap_rd", 32'(rd_data), 32'(exp_head));
        pop1();
        exp_head++;
      end
    end
    chk("wrap_level", 32'(level), 3);
    flush1();

    // Random traffic against the model.
    hold = 0;
    rst_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        if (pcm_valid_in) begin
          pcm_valid_in = 1'b0;
          hold = int'($urandom_range(1, 5));
        end else begin
          pcm_valid_in = 1'b1;
          pcm_in = 16'($urandom);
          hold = int'($urandom_range(2, 4));
        end
      end
      hold--;
      pop = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 99) == 0);
      clear_overflow = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 199) == 0)
        watermark = LW'($urandom_range(0, DEPTH + 2));
      if (rst_cnt > 0) rst_cnt--;
      else if ($urandom_range(0, 999) == 0) rst_cnt = 2;
      rst_n = (rst_cnt == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
